// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream input and register-access output bundle for the UART command decoder.
interface uart_cmd_decoder_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        rx_data;
    logic              rx_data_ready;
    logic              rx_endofpacket;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_write;
    logic              reg_read;
    logic [7:0]        rd_len;
    logic              frame_done;
    logic              frame_error;
    logic              busy;

    modport slave (
        input  rx_data, rx_data_ready, rx_endofpacket,
        output reg_addr, reg_wdata, reg_write, reg_read, rd_len,
               frame_done, frame_error, busy
    );

    modport master (
        output rx_data, rx_data_ready, rx_endofpacket,
        input  reg_addr, reg_wdata, reg_write, reg_read, rd_len,
               frame_done, frame_error, busy
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses command/length/data byte frames from a UART receiver into register
// write and read-request strobes.
//
// state  | meaning
// IDLE   | waiting for a command byte
// LEN    | command accepted, waiting for the length byte
// DATA   | write frame, receiving the remaining data bytes
module uart_cmd_decoder #(
    parameter int AUTOINC = 1,
    parameter int ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_cmd_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_is_write;
    logic [7:0]        r_remaining;

    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_reg_wdata;
    logic              r_reg_write;
    logic              r_reg_read;
    logic [7:0]        r_rd_len;
    logic              r_frame_done;
    logic              r_frame_error;
    logic              r_busy;

    logic [7:0]        w_byte;

    assign w_byte = bus.rx_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_is_write    <= 1'b0;
            r_remaining   <= 8'd0;
            r_reg_addr    <= '0;
            r_reg_wdata   <= 8'd0;
            r_reg_write   <= 1'b0;
            r_reg_read    <= 1'b0;
            r_rd_len      <= 8'd0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_reg_write   <= 1'b0;
            r_reg_read    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;

            // A byte takes priority over a coincident end-of-packet.
            if (bus.rx_data_ready) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_byte[6]) begin
                            r_frame_error <= 1'b1;
                        end else begin
                            r_addr     <= w_byte[ADDR_W-1:0];
                            r_is_write <= w_byte[7];
                            r_state    <= S_LEN;
                            r_busy     <= 1'b1;
                        end
                    end
                    S_LEN: begin
                        if (w_byte == 8'd0) begin
                            r_frame_error <= 1'b1;
                            r_state       <= S_IDLE;
                            r_busy        <= 1'b0;
                        end else if (!r_is_write) begin
                            r_reg_read   <= 1'b1;
                            r_reg_addr   <= r_addr;
                            r_rd_len     <= w_byte;
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_remaining <= w_byte;
                            r_state     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_reg_write <= 1'b1;
                        r_reg_addr  <= r_addr;
                        r_reg_wdata <= w_byte;
                        r_remaining <= r_remaining - 8'd1;
                        if (AUTOINC != 0) begin
                            r_addr <= r_addr + 1'b1;
                        end
                        if (r_remaining == 8'd1) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (bus.rx_endofpacket && (r_state != S_IDLE)) begin
                r_frame_error <= 1'b1;
                r_remaining   <= 8'd0;
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
            end
        end
    end

    assign bus.reg_addr    = r_reg_addr;
    assign bus.reg_wdata   = r_reg_wdata;
    assign bus.reg_write   = r_reg_write;
    assign bus.reg_read    = r_reg_read;
    assign bus.rd_len      = r_rd_len;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_error = r_frame_error;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed and randomized byte streams for uart_cmd_decoder, checked cycle by
// cycle against a frame-level reference model.
module tb_uart_cmd_decoder;

    localparam int AUTOINC = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder_if #(.ADDR_W(6)) bus ();

    uart_cmd_decoder #(.AUTOINC(AUTOINC), .ADDR_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model: frame progress expressed as bytes seen within the frame.
    bit       m_in_frame;
    bit       m_len_known;
    bit       m_is_wr;
    int       m_base;
    int       m_len;
    int       m_idx;

    logic [5:0] e_addr;
    logic [7:0] e_wdata, e_rdlen;
    logic       e_write, e_read, e_done, e_err, e_busy;

    task automatic model_reset();
        m_in_frame = 0; m_len_known = 0; m_is_wr = 0;
        m_base = 0; m_len = 0; m_idx = 0;
        e_addr = '0; e_wdata = '0; e_rdlen = '0;
        e_write = 0; e_read = 0; e_done = 0; e_err = 0; e_busy = 0;
    endtask

    task automatic end_frame();
        m_in_frame = 0; m_len_known = 0; e_busy = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit eop);
        e_write = 0; e_read = 0; e_done = 0; e_err = 0;
        if (v) begin
            if (!m_in_frame) begin
                if (d[6]) e_err = 1;
                else begin
                    m_in_frame = 1; m_len_known = 0; m_is_wr = d[7];
                    m_base = int'(d[5:0]); m_idx = 0; e_busy = 1;
                end
            end else if (!m_len_known) begin
                if (d == 8'h00) begin
                    e_err = 1; end_frame();
                end else if (!m_is_wr) begin
                    e_read = 1; e_addr = 6'(m_base); e_rdlen = d; e_done = 1;
                    end_frame();
                end else begin
                    m_len_known = 1; m_len = int'(d);
                end
            end else begin
                e_write = 1;
                e_addr  = 6'((AUTOINC != 0) ? (m_base + m_idx) % 64 : m_base);
                e_wdata = d;
                m_idx++;
                if (m_idx == m_len) begin
                    e_done = 1; end_frame();
                end
            end
        end else if (eop && m_in_frame) begin
            e_err = 1; end_frame();
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".reg_write"},   8'(bus.reg_write),   8'(e_write));
        chk({ctx, ".reg_read"},    8'(bus.reg_read),    8'(e_read));
        chk({ctx, ".frame_done"},  8'(bus.frame_done),  8'(e_done));
        chk({ctx, ".frame_error"}, 8'(bus.frame_error), 8'(e_err));
        chk({ctx, ".busy"},        8'(bus.busy),        8'(e_busy));
        chk({ctx, ".reg_addr"},    8'(bus.reg_addr),    8'(e_addr));
        chk({ctx, ".reg_wdata"},   bus.reg_wdata,       e_wdata);
        chk({ctx, ".rd_len"},      bus.rd_len,          e_rdlen);
    endtask

    // Drive one cycle of input at a negedge; outputs are checked at the next negedge.
    task automatic cycle(input string ctx, input bit v, input logic [7:0] d, input bit eop);
        model_step(v, d, eop);
        bus.rx_data_ready  = v;
        bus.rx_data        = d;
        bus.rx_endofpacket = eop;
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic send(input string ctx, input logic [7:0] d);
        cycle(ctx, 1'b1, d, 1'b0);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) cycle(ctx, 1'b0, 8'h00, 1'b0);
    endtask

    int wr_count;

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_data_ready = 1'b0;
        bus.rx_endofpacket = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        idle("post_reset", 1);

        // Write frame with auto-increment
        send("wr_cmd", 8'h85); send("wr_len", 8'h03);
        send("wr_d0", 8'hAA); send("wr_d1", 8'hBB); send("wr_d2", 8'hCC);
        idle("wr_after", 2);

        // Read frame
        send("rd_cmd", 8'h12); send("rd_len", 8'h04);
        idle("rd_after", 1);

        // Address wrap 0x3F -> 0x00
        send("wrap_cmd", 8'hBF); send("wrap_len", 8'h02);
        send("wrap_d0", 8'h11); send("wrap_d1", 8'h22);

        // Abort mid-write, then a read frame
        send("ab_cmd", 8'h80); send("ab_len", 8'h04); send("ab_d0", 8'h01);
        cycle("ab_eop", 1'b0, 8'h00, 1'b1);
        send("ab_rd_cmd", 8'h01); send("ab_rd_len", 8'h01);

        // Reserved bit, zero length, idle end-of-packet, byte+eop together
        send("err_rsvd", 8'h40);
        cycle("eop_idle", 1'b0, 8'h00, 1'b1);
        send("err_cmd", 8'h81); send("err_len0", 8'h00);
        send("both_cmd", 8'h87);
        cycle("both_len", 1'b1, 8'h01, 1'b1);
        cycle("both_data", 1'b1, 8'h5A, 1'b1);

        // Reset mid-frame
        send("rst_cmd", 8'h81); send("rst_len", 8'h02); send("rst_d0", 8'h55);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        idle("rst_hold", 2);
        reset_n = 1'b1;
        send("rst_d1_ignored_as_cmd", 8'h03); send("rst_rd_len", 8'h01);
        idle("rst_after", 1);

        // Randomized traffic
        wr_count = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            bit v, eop;
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            if ($urandom_range(0, 7) != 0) d[6] = 1'b0;
            if (m_in_frame && !m_len_known && $urandom_range(0, 1) == 1)
                d = 8'($urandom_range(0, 6));
            eop = ($urandom_range(0, 19) == 0);
            cycle("rand", v, d, eop);
            if (e_write) wr_count++;
        end
        idle("final", 2);

        checks++;
        assert (wr_count > 0) else begin
            failures++;
            $error("FAIL rand_coverage observed=%0d expected=nonzero", wr_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have parameter AUTOINC, default 1: 1 means the register address increments after each write byte, 0 means it stays fixed.
REQ-002 The block SHALL have parameter ADDR_W, default 6: the register address width, fixed at 6 by the frame format.
REQ-003 Port clk SHALL be an input of width 1: the single clock for all logic.
REQ-004 Port reset_n SHALL be an input of width 1: reset, asynchronous and active-low.
REQ-005 Port rx_data SHALL be an input of width 8: the received byte, valid when rx_data_ready=1.
REQ-006 Port rx_data_ready SHALL be an input of width 1: a one-cycle pulse per received byte.
REQ-007 Port rx_endofpacket SHALL be an input of width 1: a one-cycle pulse when the receive line goes idle after activity.
REQ-008 Port reg_addr SHALL be an output of width 6: the register address for reg_write or reg_read.
REQ-009 Port reg_wdata SHALL be an output of width 8: the write data, valid with reg_write.
REQ-010 Port reg_write SHALL be an output of width 1: a one-cycle write strobe.
REQ-011 Port reg_read SHALL be an output of width 1: a one-cycle read-request strobe.
REQ-012 Port rd_len SHALL be an output of width 8: the read byte count, valid with reg_read.
REQ-013 Port frame_done SHALL be an output of width 1: a one-cycle pulse when a frame completes correctly.
REQ-014 Port frame_error SHALL be an output of width 1: a one-cycle pulse when a frame is rejected or aborted.
REQ-015 Port busy SHALL be an output of width 1: 1 while the state is not IDLE.

Function
REQ-016 Frame format SHALL be: command byte, then length byte, then, for writes only, exactly LEN data bytes.
REQ-017 Command byte fields SHALL be: bit7 = 1 for write, 0 for read; bit6 reserved, must be 0; bits5:0 = start address.
REQ-018 The state machine SHALL have states IDLE, LEN and DATA; all transitions occur only on cycles where rx_data_ready=1 or rx_endofpacket=1.
REQ-019 IDLE + byte with bit6=0: latch the address and the write flag, go to LEN.
REQ-020 IDLE + byte with bit6=1: pulse frame_error, stay in IDLE.
REQ-021 LEN + byte 0x00: pulse frame_error, go to IDLE.
REQ-022 LEN + nonzero byte, read frame: pulse reg_read with reg_addr=latched address and rd_len=byte, pulse frame_done in the same cycle, go to IDLE.
REQ-023 LEN + nonzero byte, write frame: load an 8-bit remaining counter with the byte, go to DATA.
REQ-024 DATA + byte: pulse reg_write with reg_addr=current address and reg_wdata=byte; decrement remaining.
REQ-025 After each write in DATA, if AUTOINC=1, the address SHALL increment modulo 64 (0x3F wraps to 0x00).
REQ-026 When remaining goes 1→0, the block SHALL pulse frame_done together with the last reg_write and go to IDLE.
REQ-027 rx_endofpacket in LEN or DATA SHALL pulse frame_error, go to IDLE, and discard the partial frame; writes already issued are not undone.
REQ-028 rx_endofpacket in IDLE SHALL be ignored.
REQ-029 If rx_data_ready and rx_endofpacket are both 1 in the same cycle, the byte SHALL be processed and rx_endofpacket ignored in that cycle.
REQ-030 All outputs SHALL be registered, with a latency of exactly 1 clk from the rx_data_ready or rx_endofpacket pulse to the strobe.
REQ-031 Strobes SHALL be single-cycle; at most one of reg_write and reg_read is high in any cycle.
REQ-032 reg_addr, reg_wdata and rd_len SHALL hold their last value between strobes.
REQ-033 rx_data_ready SHALL be accepted every cycle with no stall or backpressure; back-to-back bytes on consecutive cycles SHALL each be processed.
REQ-034 busy SHALL go high the cycle after a valid command byte, and low the cycle after the terminating byte or the abort.

Reset
REQ-035 reset_n=0 SHALL asynchronously force: state=IDLE, remaining=0, latched address=0, and all outputs 0 (reg_addr, reg_wdata, rd_len, reg_write, reg_read, frame_done, frame_error, busy).
REQ-036 Reset mid-frame SHALL drop the frame without issuing any strobe.
REQ-037 After reset release, the first byte received SHALL be treated as a command byte.

Verification
REQ-038 Write bytes 0x85, 0x03, 0xAA, 0xBB, 0xCC -> three reg_write pulses with (addr, data) = (05,AA), (06,BB), (07,CC); frame_done coincides with the third; busy drops afterwards.
REQ-039 Read bytes 0x12, 0x04 -> one reg_read pulse with reg_addr=0x12 and rd_len=0x04, plus frame_done, one clk after the second byte; no reg_write.
REQ-040 Wrap, AUTOINC=1: bytes 0xBF, 0x02, 0x11, 0x22 -> writes (3F,11) then (00,22).
REQ-041 Abort: bytes 0x80, 0x04, 0x01, then rx_endofpacket -> one write (00,01), then frame_error; the next byte 0x01, 0x01 is parsed as a new read frame.
REQ-042 Errors: byte 0x40 -> frame_error, state stays IDLE; bytes 0x81, 0x00 -> frame_error, no write.
REQ-043 reset_n pulled low after bytes 0x81, 0x02, 0x55 -> all outputs 0 immediately; no further reg_write; after release, 0x03, 0x01 -> reg_read with reg_addr=0x03.
